harness_csr_bridge: RTL

HARNESS_CSR_BRIDGE -- requirements
Module: harness_csr_bridge

---
 rtl/harness_csr_bridge_if.sv | 37 +++
 rtl/harness_csr_bridge.sv | 98 +++++++++
 2 files changed

// File: rtl/harness_csr_bridge_if.sv
// harness_csr_bridge_if: host command/response and tile CSR signals of the bridge
interface harness_csr_bridge_if #(
    parameter int REG_WIDTH     = 32,
    parameter int CSR_IN_WIDTH  = 16,
    parameter int CSR_OUT_WIDTH = 16
);
    logic                     en_req;
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [CSR_IN_WIDTH-1:0]  cmd_csr;
    logic [REG_WIDTH-1:0]     cmd_a;
    logic [REG_WIDTH-1:0]     cmd_b;
    logic                     tile_en;
    logic [CSR_IN_WIDTH-1:0]  csr_in;
    logic [REG_WIDTH-1:0]     data_reg_a;
    logic [REG_WIDTH-1:0]     data_reg_b;
    logic                     csr_in_re;
    logic [CSR_OUT_WIDTH-1:0] csr_out;
    logic                     csr_out_we;
    logic [REG_WIDTH-1:0]     data_reg_c;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [CSR_OUT_WIDTH-1:0] rsp_csr;
    logic [REG_WIDTH-1:0]     rsp_data;
    logic                     busy;
    logic                     timeout_err;
    logic                     rsp_overflow;
    logic                     err_clr;
    modport master (
        output en_req, cmd_valid, cmd_csr, cmd_a, cmd_b, csr_in_re, csr_out, csr_out_we, data_reg_c, rsp_ready, err_clr,
        input  cmd_ready, tile_en, csr_in, data_reg_a, data_reg_b, rsp_valid, rsp_csr, rsp_data, busy, timeout_err, rsp_overflow
    );
    modport slave (
        input  en_req, cmd_valid, cmd_csr, cmd_a, cmd_b, csr_in_re, csr_out, csr_out_we, data_reg_c, rsp_ready, err_clr,
        output cmd_ready, tile_en, csr_in, data_reg_a, data_reg_b, rsp_valid, rsp_csr, rsp_data, busy, timeout_err, rsp_overflow
    );
endinterface

// File: rtl/harness_csr_bridge.sv
// harness_csr_bridge: host-to-tile CSR bridge with read-ack timeout and response FIFO
module harness_csr_bridge #(
    parameter int REG_WIDTH      = 32,
    parameter int CSR_IN_WIDTH   = 16,
    parameter int CSR_OUT_WIDTH  = 16,
    parameter int RSP_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic clk,
    input logic rst,
    harness_csr_bridge_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = $clog2(RSP_DEPTH);
    typedef enum logic {IDLE, WAIT_RE} state_t;
    state_t state_q, state_d;
    logic tile_en_q;
    logic [CSR_IN_WIDTH-1:0] csr_in_q, csr_in_d;
    logic [REG_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic tmo_q, tmo_d, ovf_q, ovf_d;
    logic accept, leave, tmo_hit;
    logic [CSR_OUT_WIDTH-1:0] mem_csr [RSP_DEPTH];
    logic [REG_WIDTH-1:0] mem_data [RSP_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    logic full, push, pop, ovf_set;
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    end
    // abort on lost enable outranks timeout, ack outranks both
    always_comb begin
        accept  = state_q == IDLE && tile_en_q && bus.cmd_valid;
        tmo_hit = state_q == WAIT_RE && !bus.csr_in_re && tile_en_q && wcnt_q == CW'(TIMEOUT_CYCLES);
        leave   = bus.csr_in_re || !tile_en_q || tmo_hit;
        state_d = state_q == IDLE ? (accept ? WAIT_RE : IDLE) : (leave ? IDLE : WAIT_RE);
    end
    always_comb begin
        bus.cmd_ready = state_q == IDLE && tile_en_q;
        bus.busy      = state_q == WAIT_RE;
    end
    always_comb begin
        csr_in_d = accept ? bus.cmd_csr : (state_q == WAIT_RE && leave) ? '0 : csr_in_q;
        a_d      = accept ? bus.cmd_a : a_q;
        b_d      = accept ? bus.cmd_b : b_q;
        wcnt_d   = accept ? '0 : state_q == WAIT_RE ? wcnt_q + 1'b1 : wcnt_q;
        full     = cnt_q == (AW+1)'(RSP_DEPTH);
        pop      = cnt_q != '0 && bus.rsp_ready;
        push     = bus.csr_out_we && (!full || pop);
        ovf_set  = bus.csr_out_we && full && !pop;
        wr_d     = wr_q + AW'(push);
        rd_d     = rd_q + AW'(pop);
        cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        tmo_d    = tmo_hit || (tmo_q && !bus.err_clr);
        ovf_d    = ovf_set || (ovf_q && !bus.err_clr);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            tile_en_q <= 1'b0;
            csr_in_q  <= '0;
            a_q       <= '0;
            b_q       <= '0;
            wcnt_q    <= '0;
            tmo_q     <= 1'b0;
            ovf_q     <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
        end else begin
            tile_en_q <= bus.en_req;
            csr_in_q  <= csr_in_d;
            a_q       <= a_d;
            b_q       <= b_d;
            wcnt_q    <= wcnt_d;
            tmo_q     <= tmo_d;
            ovf_q     <= ovf_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            mem_csr[wr_q]  <= bus.csr_out;
            mem_data[wr_q] <= bus.data_reg_c;
        end
    end
    assign bus.tile_en      = tile_en_q;
    assign bus.csr_in       = csr_in_q;
    assign bus.data_reg_a   = a_q;
    assign bus.data_reg_b   = b_q;
    assign bus.rsp_valid    = cnt_q != '0;
    assign bus.rsp_csr      = mem_csr[rd_q];
    assign bus.rsp_data     = mem_data[rd_q];
    assign bus.timeout_err  = tmo_q;
    assign bus.rsp_overflow = ovf_q;
endmodule
